// File: rtl/coalescing_write_buffer_pkg.sv
// Shared types for the dcache write-back buffer: entry layout and drain FSM states.
package coalescing_write_buffer_pkg;
  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t addr;
    word_t data;
  } wb_entry_t;

  typedef enum logic {WB_IDLE, WB_ISSUE} wb_state_t;
endpackage

// File: rtl/write_buffer_if.sv
// Bundles the write-buffer signals; wb side is the buffer, tb side drives dcache/memory.
interface write_buffer_if
  import coalescing_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic CLK,
  input logic nRST
);
  logic                     ddirtyWEN;
  word_t                    ddirtyaddr;
  word_t                    ddirtydata;
  logic                     dmissREN;
  word_t                    dmissaddr;
  logic                     dwait;
  logic                     dqueueWEN;
  word_t                    wdaddr;
  word_t                    dstore;
  logic                     wempty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     pusherr;
  logic                     fwdhit;
  word_t                    fwddata;

  modport wb (
    input  CLK, nRST, ddirtyWEN, ddirtyaddr, ddirtydata, dmissREN, dmissaddr, dwait,
    output dqueueWEN, wdaddr, dstore, wempty, full, count, pusherr, fwdhit, fwddata
  );
  modport tb (
    input  CLK, nRST, dqueueWEN, wdaddr, dstore, wempty, full, count, pusherr, fwdhit, fwddata,
    output ddirtyWEN, ddirtyaddr, ddirtydata, dmissREN, dmissaddr, dwait
  );
endinterface

// File: rtl/coalescing_write_buffer_match.sv
// Address CAM over the circular entry array; scans oldest to youngest so the youngest hit wins.
module wb_match
  import coalescing_write_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] ents,
  input  logic      [DEPTH-1:0] vld,
  input  logic      [PW-1:0]    head,
  input  word_t                 key,
  output logic                  hit,
  output logic      [PW-1:0]    idx
);
  logic [PW-1:0] i;

  always_comb begin
    hit = 1'b0;
    idx = head;
    i   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      i = head + PW'(k);
      if (vld[i] && ents[i].addr == key) begin
        hit = 1'b1;
        idx = i;
      end
    end
  end
endmodule

// File: rtl/coalescing_write_buffer.sv
// Dcache write-back buffer: queues evictions, merges repeat writes, drains when no miss
// is pending, and forwards queued data to the pending miss read.
module coalescing_write_buffer
  import coalescing_write_buffer_pkg::*;
#(
  parameter  int DEPTH    = 4,
  parameter  bit COALESCE = 1'b1,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          ddirtyWEN,
  input  word_t         ddirtyaddr,
  input  word_t         ddirtydata,
  input  logic          dmissREN,
  input  word_t         dmissaddr,
  input  logic          dwait,
  output logic          dqueueWEN,
  output word_t         wdaddr,
  output word_t         dstore,
  output logic          wempty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          pusherr,
  output logic          fwdhit,
  output word_t         fwddata
);
  wb_entry_t [DEPTH-1:0] ents;
  logic [PW-1:0]         head, tail, cidx, fidx;
  logic [DEPTH-1:0]      vld, cvld;
  logic                  chit, merge, alloc, pop;
  wb_state_t             state, nstate;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    vld  = '0;
    cvld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i]  = {1'b0, PW'(i) - head} < count;
      cvld[i] = vld[i] && !(state == WB_ISSUE && PW'(i) == head);
    end
  end

  wb_match #(.DEPTH(DEPTH)) u_cmatch (
    .ents(ents), .vld(cvld), .head(head), .key(ddirtyaddr), .hit(chit), .idx(cidx)
  );
  wb_match #(.DEPTH(DEPTH)) u_fmatch (
    .ents(ents), .vld(vld), .head(head), .key(dmissaddr), .hit(fwdhit), .idx(fidx)
  );

  assign wempty  = count == '0;
  assign full    = count == CW'(DEPTH);
  assign merge   = ddirtyWEN && COALESCE && chit;
  assign alloc   = ddirtyWEN && !merge && !full;
  assign pop     = state == WB_ISSUE && !dwait;
  assign wdaddr  = ents[head].addr;
  assign dstore  = ents[head].data;
  assign fwddata = fwdhit ? ents[fidx].data : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ents    <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pusherr <= 1'b0;
    end else begin
      if (merge) ents[cidx].data <= ddirtydata;
      if (alloc) begin
        ents[tail] <= '{addr: ddirtyaddr, data: ddirtydata};
        tail       <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count   <= count + CW'(alloc) - CW'(pop);
      pusherr <= ddirtyWEN && !merge && full;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= WB_IDLE;
    else       state <= nstate;
  end

  // A raised miss only stops the next drain; an accepted-pending write is never abandoned.
  always_comb begin
    nstate = state;
    case (state)
      WB_IDLE:  if (!wempty && !dmissREN) nstate = WB_ISSUE;
      WB_ISSUE: if (!dwait) nstate = (count > CW'(1) && !dmissREN) ? WB_ISSUE : WB_IDLE;
      default:  nstate = WB_IDLE;
    endcase
  end

  always_comb begin
    dqueueWEN = (state == WB_ISSUE);
  end
endmodule

// File: tb/tb_coalescing_write_buffer.sv
// Self-checking bench: two buffers (merging and non-merging) driven in lockstep against
// a queue-based reference model, plus directed scenarios with literal expectations.
module tb_coalescing_write_buffer;
  import coalescing_write_buffer_pkg::*;
  localparam int DEPTH = 4;
  typedef word_t wq_t[$];

  logic CLK = 1'b0, nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic  wen, miss, dw;
  word_t addr, data, maddr;
  logic  dq[2], we[2], fu[2], pe[2], fh[2];
  word_t wda[2], dst[2], fwd[2];
  logic [2:0] cn[2];

  coalescing_write_buffer #(.DEPTH(DEPTH), .COALESCE(1'b1)) dut0 (
    .CLK(CLK), .nRST(nRST), .ddirtyWEN(wen), .ddirtyaddr(addr), .ddirtydata(data),
    .dmissREN(miss), .dmissaddr(maddr), .dwait(dw), .dqueueWEN(dq[0]), .wdaddr(wda[0]),
    .dstore(dst[0]), .wempty(we[0]), .full(fu[0]), .count(cn[0]), .pusherr(pe[0]),
    .fwdhit(fh[0]), .fwddata(fwd[0]));

  coalescing_write_buffer #(.DEPTH(DEPTH), .COALESCE(1'b0)) dut1 (
    .CLK(CLK), .nRST(nRST), .ddirtyWEN(wen), .ddirtyaddr(addr), .ddirtydata(data),
    .dmissREN(miss), .dmissaddr(maddr), .dwait(dw), .dqueueWEN(dq[1]), .wdaddr(wda[1]),
    .dstore(dst[1]), .wempty(we[1]), .full(fu[1]), .count(cn[1]), .pusherr(pe[1]),
    .fwdhit(fh[1]), .fwddata(fwd[1]));

  int    nvec = 0, nerr = 0;
  word_t qa[2][$], qd[2][$];
  bit    iss[2], perr[2];
  word_t loga[$], logd[$];

  task automatic chk(string nm, word_t act, word_t exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      qa[m].delete(); qd[m].delete(); iss[m] = 0; perr[m] = 0;
    end
  endtask

  // Entered just after a negedge with inputs set; returns at the following negedge.
  task automatic step();
    #1;
    for (int m = 0; m < 2; m++) begin
      int    sz;
      bit    h;
      word_t fd;
      sz = qa[m].size(); h = 0; fd = '0;
      for (int i = 0; i < sz; i++) if (qa[m][i] == maddr) begin h = 1; fd = qd[m][i]; end
      chk($sformatf("count%0d", m), word_t'(cn[m]), word_t'(sz));
      chk($sformatf("wempty%0d", m), word_t'(we[m]), word_t'(sz == 0));
      chk($sformatf("full%0d", m), word_t'(fu[m]), word_t'(sz == DEPTH));
      chk($sformatf("pusherr%0d", m), word_t'(pe[m]), word_t'(perr[m]));
      chk($sformatf("dqueueWEN%0d", m), word_t'(dq[m]), word_t'(iss[m]));
      chk($sformatf("fwdhit%0d", m), word_t'(fh[m]), word_t'(h));
      chk($sformatf("fwddata%0d", m), fwd[m], fd);
      if (iss[m] && sz > 0) begin
        chk($sformatf("wdaddr%0d", m), wda[m], qa[m][0]);
        chk($sformatf("dstore%0d", m), dst[m], qd[m][0]);
      end
    end
    if (dq[0] === 1'b1 && !dw) begin loga.push_back(wda[0]); logd.push_back(dst[0]); end
    @(posedge CLK);
    for (int m = 0; m < 2; m++) begin
      int sz, f;
      bit pop, nis, al;
      sz = qa[m].size(); f = -1; al = 0;
      pop = iss[m] && !dw;
      if (!iss[m])  nis = (sz > 0) && !miss;
      else if (!dw) nis = (sz > 1) && !miss;
      else          nis = 1;
      perr[m] = 0;
      if (wen) begin
        if (m == 0)
          for (int i = sz - 1; i >= (iss[m] ? 1 : 0); i--)
            if (f < 0 && qa[m][i] == addr) f = i;
        if (f >= 0)          qd[m][f] = data;
        else if (sz < DEPTH) al = 1;
        else                 perr[m] = 1;
      end
      if (pop) begin void'(qa[m].pop_front()); void'(qd[m].pop_front()); end
      if (al) begin qa[m].push_back(addr); qd[m].push_back(data); end
      iss[m] = nis;
    end
    @(negedge CLK);
  endtask

  task automatic cyc(bit w, word_t a, word_t d, bit mi, bit dwt);
    wen = w; addr = a; data = d; miss = mi; dw = dwt;
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    wen = 0; miss = 0; dw = 0;
    while ((qa[0].size() > 0 || qa[1].size() > 0 || iss[0] || iss[1]) && n < 20) begin
      step(); n++;
    end
    chk("drain_empty0", word_t'(we[0]), 32'd1);
    chk("drain_empty1", word_t'(we[1]), 32'd1);
  endtask

  task automatic chk_log(string nm, wq_t ea, wq_t ed);
    chk({nm, "_len"}, word_t'(loga.size()), word_t'(ea.size()));
    for (int i = 0; i < ea.size() && i < loga.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), loga[i], ea[i]);
      chk($sformatf("%s_data%0d", nm, i), logd[i], ed[i]);
    end
    loga.delete(); logd.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    wq_t ea, ed;
    wen = 1; addr = 32'h10; data = 32'h1; miss = 0; dw = 0; maddr = 32'h10;
    model_clear();
    // Reset held while a push is requested
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_wempty", word_t'(we[0]), 32'd1);
    chk("rst_count", word_t'(cn[0]), 32'd0);
    chk("rst_dqueueWEN", word_t'(dq[0]), 32'd0);
    chk("rst_full", word_t'(fu[0]), 32'd0);
    chk("rst_fwdhit", word_t'(fh[0]), 32'd0);
    wen = 0;
    @(negedge CLK);
    nRST = 1;

    // Fill to full, refused fifth push, in-order drain
    cyc(1, 32'h10, 32'hA0, 0, 1);
    cyc(1, 32'h14, 32'hA1, 0, 1);
    cyc(1, 32'h18, 32'hA2, 0, 1);
    cyc(1, 32'h1C, 32'hA3, 0, 1);
    chk("fill_full", word_t'(fu[0]), 32'd1);
    cyc(1, 32'h20, 32'hE0, 0, 1);
    chk("fill_pusherr", word_t'(pe[0]), 32'd1);
    cyc(0, 32'h0, 32'h0, 0, 1);
    drain();
    ea = '{32'h10, 32'h14, 32'h18, 32'h1C}; ed = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    chk_log("fill", ea, ed);

    // Coalescing a repeat address
    cyc(1, 32'h100, 32'h11, 1, 0);
    cyc(1, 32'h104, 32'h22, 1, 0);
    cyc(1, 32'h100, 32'h33, 1, 0);
    chk("coal_count0", word_t'(cn[0]), 32'd2);
    chk("coal_count1", word_t'(cn[1]), 32'd3);
    drain();
    ea = '{32'h100, 32'h104}; ed = '{32'h33, 32'h22};
    chk_log("coal", ea, ed);

    // Repeat address while head is in flight allocates a new entry
    cyc(1, 32'h200, 32'h44, 0, 1);
    cyc(0, 32'h0, 32'h0, 0, 1);
    chk("infl_issue", word_t'(dq[0]), 32'd1);
    cyc(1, 32'h200, 32'h55, 0, 1);
    chk("infl_count", word_t'(cn[0]), 32'd2);
    drain();
    ea = '{32'h200, 32'h200}; ed = '{32'h44, 32'h55};
    chk_log("infl", ea, ed);

    // Pending miss blocks the drain start
    cyc(1, 32'h400, 32'h1, 1, 0);
    cyc(1, 32'h404, 32'h2, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("miss_block", word_t'(dq[0]), 32'd0);
    cyc(0, 32'h0, 32'h0, 0, 0);
    chk("miss_release", word_t'(dq[0]), 32'd1);
    drain();
    loga.delete(); logd.delete();

    // Forwarding picks the youngest match
    cyc(1, 32'h300, 32'h1, 1, 0);
    cyc(1, 32'h300, 32'h2, 1, 0);
    wen = 0; maddr = 32'h300;
    #1;
    chk("fwd_hit1", word_t'(fh[1]), 32'd1);
    chk("fwd_data1", fwd[1], 32'h2);
    chk("fwd_data0", fwd[0], 32'h2);
    step();
    maddr = 32'h304;
    #1;
    chk("fwd_miss_hit", word_t'(fh[1]), 32'd0);
    chk("fwd_miss_data", fwd[1], 32'h0);
    step();
    drain();

    // Randomized traffic with one asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        nRST = 0;
        model_clear();
        #1;
        chk("mid_rst_wempty", word_t'(we[0]), 32'd1);
        chk("mid_rst_dq", word_t'(dq[1]), 32'd0);
        wen = 0;
        @(negedge CLK);
        nRST = 1;
      end
      maddr = 32'h100 + 4 * ($urandom % 6);
      cyc(1'($urandom % 2), 32'h100 + 4 * ($urandom % 6), $urandom,
          ($urandom % 4) == 0, ($urandom % 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
